stbus_frame_rx: RTL

// - Receive side of the framed serial link driven by our f0/c4 burst generator (f0 frame strobe, c4 bit clock, clk1 bursts).
// - Oversamples f0, c4 and din in the system clock domain.
// - Frames NBITS serial bits following each f0 strobe and presents each completed word on a valid/ready output port.
// - Sits between the serial pins and the register/datapath logic running on clk.

---
 rtl/stbus_frame_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stbus_frame_rx.sv
// stbus_frame_rx: oversampling receiver for the f0/c4/din framed serial link.
// Optional frame counter (wr/wdata/frame_cnt) is built when STBUS_RX_FRAMECNT_EN is defined.
module stbus_frame_rx #(
   parameter int NBITS       = 32,
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
`ifdef STBUS_RX_FRAMECNT_EN
   input  logic             wr,
   input  logic [7:0]       wdata,
   output logic [7:0]       frame_cnt,
`endif
   input  logic             f0,
   input  logic             c4,
   input  logic             din,
   output logic [NBITS-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_ovr,
   output logic             frame_err,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [5:0] LAST    = 6'(NBITS - 1);

   logic [SYNC_STAGES-1:0] f0_sync;
   logic [SYNC_STAGES-1:0] c4_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic                   f0_d;
   logic                   c4_d;
   logic                   f0_s;
   logic                   c4_s;
   logic                   din_s;
   logic                   f0_fall;
   logic                   c4_rise;
   logic                   c4_fall;

   logic [1:0]       state;
   logic [5:0]       cnt;
   logic             done;
   logic [NBITS-1:0] shreg;
   logic [NBITS-1:0] shift_nxt;
   logic             xfer;
   logic             accept;

   assign f0_s  = f0_sync[SYNC_STAGES-1];
   assign c4_s  = c4_sync[SYNC_STAGES-1];
   assign din_s = din_sync[SYNC_STAGES-1];

   assign f0_fall = f0_d & ~f0_s;
   assign c4_rise = ~c4_d & c4_s;
   assign c4_fall = c4_d & ~c4_s;

   assign shift_nxt = MSB_FIRST ? {shreg[NBITS-2:0], din_s}
                                : {din_s, shreg[NBITS-1:1]};

   // done marks a fully shifted word; an f0 edge in the same cycle wins
   assign xfer   = (state == S_SHIFT) & done & ~f0_fall;
   assign accept = rx_valid & rx_ready;
   assign busy   = (state != S_IDLE);

   // Synchronise the pins and keep a delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         f0_sync  <= '1;
         c4_sync  <= '1;
         din_sync <= '1;
         f0_d     <= 1'b1;
         c4_d     <= 1'b1;
      end else begin
         f0_sync  <= {f0_sync[SYNC_STAGES-2:0], f0};
         c4_sync  <= {c4_sync[SYNC_STAGES-2:0], c4};
         din_sync <= {din_sync[SYNC_STAGES-2:0], din};
         f0_d     <= f0_s;
         c4_d     <= c4_s;
      end
   end

   // Frame FSM: arm on f0, shift on c4 rising edges, abort on a new f0
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         done      <= 1'b0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (f0_fall) begin
            if (state != S_IDLE) frame_err <= 1'b1;
            state <= S_ARMED;
            cnt   <= '0;
            done  <= 1'b0;
            shreg <= '0;
         end else begin
            case (state)
               S_IDLE: begin
               end
               S_ARMED: begin
                  if (c4_fall) state <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (done) begin
                     state <= S_IDLE;
                     cnt   <= '0;
                     done  <= 1'b0;
                  end else if (c4_rise) begin
                     shreg <= shift_nxt;
                     cnt   <= cnt + 6'd1;
                     if (cnt == LAST) done <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Output word register with valid/ready handshake and sticky overrun
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
      end else if (xfer) begin
         rx_data  <= shreg;
         rx_valid <= 1'b1;
         if (rx_valid && !rx_ready) rx_ovr <= 1'b1;
         else if (accept)           rx_ovr <= 1'b0;
      end else if (accept) begin
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
      end
   end

`ifdef STBUS_RX_FRAMECNT_EN
   // Completed-frame counter; a load beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (!reset)    frame_cnt <= 8'h00;
      else if (wr)   frame_cnt <= wdata;
      else if (xfer) frame_cnt <= frame_cnt + 8'd1;
   end
`endif

endmodule
